// File: rtl/bram_checker.sv
// Read-back checker for a 16-entry BRAM: compares each newly addressed word
// against PATTERN_SEED ^ addr after READ_LAT edges and reports a sweep verdict.
module bram_checker #(
  parameter int                DATA_W       = 8,
  parameter int                READ_LAT     = 1,
  parameter logic [DATA_W-1:0] PATTERN_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [3:0]        addra,
  input  logic [DATA_W-1:0] douta,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [4:0]        err_count,
  output logic [4:0]        check_count,
  output logic [3:0]        first_err_addr,
  output logic              first_err_valid,
  output logic              err_pulse,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state, state_d;
  logic [3:0]        addr_q;
  logic [3:0]        chk_addr;
  logic [1:0]        wait_cnt;
  logic              change;
  logic              cmp;
  logic              mismatch;
  logic [DATA_W-1:0] expected;

  assign change   = (addra != addr_q);
  assign expected = PATTERN_SEED ^ {{(DATA_W-4){1'b0}}, chk_addr};
  assign mismatch = cmp && (douta != expected);
  assign pass     = done && (err_count == 5'd0);
  assign fail     = done && (err_count != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      addr_q <= 4'd0;
    end else begin
      state  <= state_d;
      addr_q <= addra;
    end
  end

  always_comb begin
    state_d = state;
    cmp     = 1'b0;
    case (state)
      IDLE: if (change) state_d = WAIT;
      WAIT: if (wait_cnt == 2'd1) begin
        cmp     = 1'b1;
        state_d = (check_count == 5'd15) ? DONE : IDLE;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    // clear wins over a compare landing on the same edge
    if (clear) begin
      state_d = IDLE;
      cmp     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_addr        <= 4'd0;
      wait_cnt        <= 2'd0;
      done            <= 1'b0;
      err_count       <= 5'd0;
      check_count     <= 5'd0;
      first_err_addr  <= 4'd0;
      first_err_valid <= 1'b0;
      err_pulse       <= 1'b0;
      overrun         <= 1'b0;
    end else if (clear) begin
      wait_cnt        <= 2'd0;
      done            <= 1'b0;
      err_count       <= 5'd0;
      check_count     <= 5'd0;
      first_err_addr  <= 4'd0;
      first_err_valid <= 1'b0;
      err_pulse       <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      err_pulse <= mismatch;
      if (state == IDLE && change) begin
        chk_addr <= addra;
        wait_cnt <= 2'(READ_LAT);
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt - 2'd1;
        // the new address is dropped; the pending check still completes
        if (change) overrun <= 1'b1;
      end
      if (cmp) begin
        check_count <= check_count + 5'd1;
        if (check_count == 5'd15) done <= 1'b1;
      end
      if (mismatch) begin
        err_count <= err_count + 5'd1;
        if (!first_err_valid) begin
          first_err_addr  <= chk_addr;
          first_err_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_checker.sv
// Bench for bram_checker: READ_LAT=1 and READ_LAT=3 instances share stimulus and
// are checked every cycle against an edge-counting model, plus literal spot checks.
module tb_bram_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  addra = 4'd0;
  logic [7:0]  douta;
  logic [7:0]  mem [16];

  logic [1:0]      done, pass, fail, fev, err_pulse, overrun;
  logic [1:0][4:0] ec, cc;
  logic [1:0][3:0] fea;

  int n_checks = 0;
  int n_errors = 0;
  int pulses0  = 0;

  always #5 clk = ~clk;
  assign douta = mem[addra];

  bram_checker #(.DATA_W(8), .READ_LAT(1), .PATTERN_SEED(8'hA5)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .addra(addra), .douta(douta),
    .done(done[0]), .pass(pass[0]), .fail(fail[0]), .err_count(ec[0]),
    .check_count(cc[0]), .first_err_addr(fea[0]), .first_err_valid(fev[0]),
    .err_pulse(err_pulse[0]), .overrun(overrun[0]));

  bram_checker #(.DATA_W(8), .READ_LAT(3), .PATTERN_SEED(8'hA5)) u3 (
    .clk(clk), .reset(reset), .clear(clear), .addra(addra), .douta(douta),
    .done(done[1]), .pass(pass[1]), .fail(fail[1]), .err_count(ec[1]),
    .check_count(cc[1]), .first_err_addr(fea[1]), .first_err_valid(fev[1]),
    .err_pulse(err_pulse[1]), .overrun(overrun[1]));

  // Model: a check is scheduled at absolute edge number (detect edge + latency).
  int lat [2] = '{1, 3};
  int cyc, prev_addr;
  int m_checks [2], m_errs [2], m_fea [2], m_pend_at [2], m_pend_addr [2];
  bit m_done [2], m_ovr [2], m_pulse [2], m_fev [2], m_pend [2];

  task automatic model_reset();
    prev_addr = 0;
    for (int i = 0; i < 2; i++) begin
      m_checks[i] = 0; m_errs[i] = 0; m_fea[i] = 0; m_fev[i] = 0;
      m_done[i] = 0; m_ovr[i] = 0; m_pulse[i] = 0; m_pend[i] = 0;
    end
  endtask

  task automatic model_step();
    bit chg;
    cyc++;
    chg = (int'(addra) != prev_addr);
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 0;
      if (clear) begin
        m_checks[i] = 0; m_errs[i] = 0; m_fea[i] = 0; m_fev[i] = 0;
        m_done[i] = 0; m_ovr[i] = 0; m_pend[i] = 0;
      end else if (!m_done[i]) begin
        if (m_pend[i]) begin
          if (chg) m_ovr[i] = 1;
          if (cyc == m_pend_at[i]) begin
            m_pend[i] = 0;
            m_checks[i]++;
            if (int'(douta) != ((8'hA5 ^ m_pend_addr[i]) & 8'hFF)) begin
              m_errs[i]++;
              m_pulse[i] = 1;
              if (!m_fev[i]) begin m_fev[i] = 1; m_fea[i] = m_pend_addr[i]; end
            end
            if (m_checks[i] == 16) m_done[i] = 1;
          end
        end else if (chg) begin
          m_pend[i] = 1;
          m_pend_at[i] = cyc + lat[i];
          m_pend_addr[i] = int'(addra);
        end
      end
    end
    prev_addr = int'(addra);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare of every output of both instances
  initial begin
    logic [19:0] act, exp_v;
    forever begin
      @(negedge clk);
      if (err_pulse[0]) pulses0++;
      for (int i = 0; i < 2; i++) begin
        act = {done[i], pass[i], fail[i], ec[i], cc[i], fea[i], fev[i], err_pulse[i], overrun[i]};
        exp_v = {m_done[i], m_done[i] && m_errs[i] == 0, m_done[i] && m_errs[i] != 0,
                 5'(m_errs[i]), 5'(m_checks[i]), 4'(m_fea[i]), m_fev[i], m_pulse[i], m_ovr[i]};
        n_checks++;
        if (act !== exp_v) begin
          n_errors++;
          $display("FAIL cycle %0d lat%0d outputs: got done=%0d pass=%0d fail=%0d err=%0d chk=%0d fea=%0d fev=%0d pulse=%0d ovr=%0d; expected done=%0d pass=%0d fail=%0d err=%0d chk=%0d fea=%0d fev=%0d pulse=%0d ovr=%0d",
                   cyc, lat[i], act[19], act[18], act[17], act[16:12], act[11:7], act[6:3], act[2], act[1], act[0],
                   exp_v[19], exp_v[18], exp_v[17], exp_v[16:12], exp_v[11:7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_addr(int a, int gap);
    addra = 4'(a);
    tick(gap);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic fill_mem();
    for (int a = 0; a < 16; a++) mem[a] = 8'hA5 ^ 8'(a);
  endtask

  task automatic sweep();
    for (int a = 1; a <= 16; a++) set_addr(a % 16, 3);
    tick(4);
  endtask

  initial begin
    int p0, hold_ec, hold_cc;
    fill_mem();
    #1 reset = 1'b0;
    #1;
    chk("reset done", done[0], 0);
    chk("reset check_count", cc[1], 0);
    chk("reset err_pulse", err_pulse[0], 0);
    tick(3);
    reset = 1'b1;
    tick(1);

    // clean sweep
    p0 = pulses0;
    sweep();
    chk("clean check_count", cc[0], 16);
    chk("clean err_count", ec[0], 0);
    chk("clean pass", pass[0], 1);
    chk("clean fail", fail[0], 0);
    chk("clean pulses", pulses0 - p0, 0);

    // single corruption at address 7
    do_clear();
    mem[7] = 8'h00;
    p0 = pulses0;
    sweep();
    chk("single err_count", ec[0], 1);
    chk("single first_err_addr", fea[0], 7);
    chk("single first_err_valid", fev[0], 1);
    chk("single fail", fail[0], 1);
    chk("single pulses", pulses0 - p0, 1);

    // three corruptions, 3 seen first in the sweep
    do_clear();
    fill_mem();
    mem[3] = 8'h11; mem[9] = 8'hFF; mem[0] = 8'h5A;
    p0 = pulses0;
    sweep();
    chk("multi err_count", ec[0], 3);
    chk("multi first_err_addr", fea[0], 3);
    chk("multi pulses", pulses0 - p0, 3);

    // done holds through further address changes
    hold_ec = ec[0];
    hold_cc = cc[0];
    for (int a = 1; a <= 4; a++) set_addr(a, 3);
    tick(3);
    chk("hold err_count", ec[0], hold_ec);
    chk("hold check_count", cc[0], hold_cc);
    chk("hold fail", fail[0], 1);
    chk("hold overrun", overrun[0], 0);

    // back-to-back changes with READ_LAT=3
    do_clear();
    fill_mem();
    set_addr(1, 1);
    set_addr(2, 6);
    chk("overrun lat3 flag", overrun[1], 1);
    chk("overrun lat3 check_count", cc[1], 1);

    // clear after five checks
    do_clear();
    for (int a = 3; a <= 7; a++) set_addr(a, 3);
    tick(3);
    chk("pre-clear check_count", cc[0], 5);
    do_clear();
    chk("clear check_count", cc[0], 0);
    chk("clear err_count", ec[0], 0);
    chk("clear overrun", overrun[1], 0);

    // reset while a check is pending
    set_addr(9, 3);
    addra = 4'd10;
    tick(1);
    reset = 1'b0;
    #1;
    chk("async reset check_count", cc[0], 0);
    addra = 4'd0;
    tick(2);
    reset = 1'b1;
    tick(6);
    chk("post-reset check_count lat1", cc[0], 0);
    chk("post-reset check_count lat3", cc[1], 0);

    // randomized traffic against the model
    do_clear();
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 5) do_clear();
      else if (r < 15) begin
        mem[$urandom_range(0, 15)] = 8'($urandom);
        tick(1);
      end else if (r < 20) fill_mem();
      else set_addr($urandom_range(0, 15), $urandom_range(1, 4));
    end
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bram_checker.md
# bram_checker

Read-back checker that sits directly downstream of the BRAM address sequencer and its 16-entry block RAM. It watches the 4-bit read address the sequencer drives, waits the RAM read latency, and compares the returned data word against a fixed address-derived pattern. It accumulates error statistics and, after one full 16-address sweep, raises a pass/fail verdict for LEDs or a status register.

## Interface
- DATA_W, 8, width of the BRAM data word; must be ≥ 4
- READ_LAT, 1, edges from change detection to data sample; legal range 1..3
- PATTERN_SEED, 8'hA5, expected word is PATTERN_SEED XOR zero-extended address

- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous; restarts a sweep and zeroes all statistics
- addra  in  4  read address from the sequencer; registered upstream, so it changes only on clk edges
- douta  in  DATA_W  BRAM read data for addra, valid READ_LAT edges after addra changes
- done  out  1  sweep complete (16 checks taken); sticky until clear or reset
- pass  out  1  done & (err_count == 0)
- fail  out  1  done & (err_count != 0)
- err_count  out  5  number of mismatching words in the current sweep, 0..16
- check_count  out  5  number of words compared in the current sweep, 0..16
- first_err_addr  out  4  address of the first mismatch in the sweep
- first_err_valid  out  1  first_err_addr holds a valid address
- err_pulse  out  1  one-cycle strobe on every mismatch
- overrun  out  1  sticky; addra changed while a check was pending

## Operation
- Internal addr_q register follows addra every cycle and resets to 0, matching the sequencer's reset address.
- A change is detected when addra != addr_q.
- States:
  - IDLE: on a change, capture addra into chk_addr, load wait_cnt = READ_LAT, and go to WAIT.
  - WAIT: decrement wait_cnt each cycle. On the edge where wait_cnt == 1, compare douta against PATTERN_SEED ^ {0, chk_addr} and increment check_count. On a mismatch, also increment err_count and pulse err_pulse. If this was the 16th check, go to DONE; otherwise go to IDLE.
  - DONE: hold all outputs. Ignore further address changes; overrun is not set.
- First mismatch of a sweep loads first_err_addr and sets first_err_valid. Later mismatches do not change them.
- A change detected in WAIT sets overrun. That address is not checked, and the pending check completes normally.
- Addresses are covered only on change. After reset the order is 1,2,…,15,0, with the 15→0 wrap counted as a change.
- If the same address reappears after a non-change, it is not re-checked.
- clear (any state): go to IDLE and zero err_count, check_count, first_err_*, overrun, and done. addr_q keeps tracking addra. clear has priority over a simultaneous compare.
- Counters are 5-bit and never exceed 16, so no saturation is needed.

## Timing
- Reset (asynchronous assert, async-low): every output = 0, state = IDLE, addr_q = 0, wait_cnt = 0.
- Let E0 be the edge at which the change is detected.
- The compare uses douta sampled at edge E0+READ_LAT.
- At that same edge: err_count and check_count update, err_pulse registers high for exactly one cycle, and first_err_* load.
- done, pass, and fail assert at the edge of the 16th compare (registered, no extra cycle).
- The sequencer changes addra at most once every 3 cycles, so READ_LAT ≤ 2 never overruns at its maximum rate. READ_LAT = 3 can overrun; this is intended as a diagnostic.
- A reset mid-WAIT discards the pending check with no partial update.

## Test plan
- Clean sweep: BRAM holds A5^addr, step addra 0→1→…→15→0, 3 cycles apart, READ_LAT = 1 → check_count = 16, err_count = 0, pass = 1 at the 16th compare edge, err_pulse never high.
- Single corruption: word at address 7 = 8'h00 → err_count = 1, first_err_addr = 7, first_err_valid = 1, one err_pulse, fail = 1 after the sweep.
- Multiple errors: corrupt addresses 3, 9, 0 → err_count = 3, first_err_addr stays 3, 3 err_pulses.
- Overrun: READ_LAT = 3, change addra on consecutive edges 1→2 → overrun = 1, only address 1 is checked (check_count = 1).
- Clear and reset: assert clear at check_count = 5 → all statistics 0, IDLE. Pull reset low during WAIT → all outputs 0 immediately, and no compare occurs after release.
- Done hold: after done, step addra through 4 more values → counters, pass/fail, and overrun are unchanged.
